// File: rtl/uart_cmd_selector.sv
// uart_cmd_selector: two-byte UART command framer (address byte, then request byte) with device select and error reporting
module uart_cmd_selector #(
    parameter int DATA_W      = 8,
    parameter int NUM_DEV     = 4,
    parameter int BASE_ADDR   = 8'hC8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              i_Clock,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Data_Done,
    input  logic              i_Ack,
    output logic [DATA_W-1:0] o_address,
    output logic [DATA_W-1:0] o_request,
    output logic [NUM_DEV-1:0] o_dev_sel,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W:0] LO = BASE_ADDR[DATA_W:0];
    localparam logic [DATA_W:0] HI = LO + (DATA_W+1)'(NUM_DEV);

    typedef enum logic [1:0] {IDLE, WAIT_REQ, HOLD} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   addr_n, req_n;
    logic [NUM_DEV-1:0]  sel_n, sel_dec;
    logic                done_n, busy_n, err_n;
    logic [1:0]          code_n;
    logic                in_range;

    assign in_range = ({1'b0, i_Data} >= LO) && ({1'b0, i_Data} < HI);
    assign sel_dec  = NUM_DEV'(1) << (o_address - LO[DATA_W-1:0]);

    // next-state and next-output logic; every output is updated only through its register
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = o_address;
        req_n   = o_request;
        sel_n   = o_dev_sel;
        done_n  = o_done;
        busy_n  = o_busy;
        err_n   = 1'b0;
        code_n  = o_err_code;
        case (state)
            IDLE: begin
                if (i_Data_Done && in_range) begin
                    addr_n  = i_Data;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = WAIT_REQ;
                end else if (i_Data_Done) begin
                    err_n  = 1'b1;
                    code_n = 2'b01;
                end
            end
            WAIT_REQ: begin
                if (i_Data_Done) begin
                    req_n   = i_Data;
                    done_n  = 1'b1;
                    sel_n   = sel_dec;
                    state_n = HOLD;
                end else if (cnt == LAST) begin
                    err_n   = 1'b1;
                    code_n  = 2'b10;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (i_Data_Done) begin
                    err_n  = 1'b1;
                    code_n = 2'b11;
                end
                if (i_Ack) begin
                    done_n  = 1'b0;
                    sel_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers with asynchronous clear
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_address  <= '0;
            o_request  <= '0;
            o_dev_sel  <= '0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'b00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            o_address  <= addr_n;
            o_request  <= req_n;
            o_dev_sel  <= sel_n;
            o_done     <= done_n;
            o_busy     <= busy_n;
            o_err      <= err_n;
            o_err_code <= code_n;
        end
    end
endmodule

// File: tb/tb_uart_cmd_selector.sv
// tb_uart_cmd_selector: directed scenarios plus randomized traffic against a frame-level reference model
module tb_uart_cmd_selector;
    localparam int TO = 16;

    logic       i_Clock = 1'b0;
    logic       i_Rst = 1'b1;
    logic [7:0] i_Data = 8'h00;
    logic       i_Data_Done = 1'b0;
    logic       i_Ack = 1'b0;
    logic [7:0] o_address, o_request;
    logic [3:0] o_dev_sel;
    logic       o_done, o_busy, o_err;
    logic [1:0] o_err_code;

    int checks = 0;
    int errors = 0;

    uart_cmd_selector #(.DATA_W(8), .NUM_DEV(4), .BASE_ADDR(8'hC8), .TIMEOUT_CYC(TO)) dut (
        .i_Clock(i_Clock), .i_Rst(i_Rst), .i_Data(i_Data), .i_Data_Done(i_Data_Done), .i_Ack(i_Ack),
        .o_address(o_address), .o_request(o_request), .o_dev_sel(o_dev_sel), .o_done(o_done),
        .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 i_Clock = ~i_Clock;

    // reference model: frame-level view (waiting for request? frame held? cycles since address)
    logic [7:0] m_addr, m_req;
    logic [3:0] m_sel;
    logic       m_done, m_busy, m_err;
    logic [1:0] m_code;
    bit         m_waiting, m_held;
    int         m_age;

    task automatic model_reset();
        m_addr = 0; m_req = 0; m_sel = 0; m_done = 0; m_busy = 0; m_err = 0; m_code = 0;
        m_waiting = 0; m_held = 0; m_age = 0;
    endtask

    task automatic model_step(input bit dd, input logic [7:0] d, input bit ack);
        m_err = 0;
        if (m_held) begin
            if (dd) begin m_err = 1; m_code = 2'd3; end
            if (ack) begin m_held = 0; m_done = 0; m_sel = 0; end
        end else if (m_waiting) begin
            if (dd) begin
                m_req = d; m_held = 1; m_waiting = 0; m_done = 1;
                m_sel = 4'(1 << (int'(m_addr) - 200));
            end else begin
                m_age++;
                if (m_age >= TO) begin m_err = 1; m_code = 2'd2; m_waiting = 0; end
            end
        end else if (dd) begin
            if (int'(d) >= 200 && int'(d) < 204) begin m_addr = d; m_waiting = 1; m_age = 0; end
            else begin m_err = 1; m_code = 2'd1; end
        end
        m_busy = m_waiting || m_held;
    endtask

    task automatic tick(input bit dd, input logic [7:0] d, input bit ack);
        i_Data_Done = dd; i_Data = d; i_Ack = ack;
        @(posedge i_Clock);
        #1;
        i_Data_Done = 0; i_Ack = 0;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1, d, 0);
    endtask

    task automatic do_reset();
        i_Rst = 1;
        @(posedge i_Clock);
        #1;
        i_Rst = 0;
    endtask

    task automatic test_reset();
        i_Rst = 1;
        #2;
        checks++;
        if ({o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h req=%h sel=%b done=%b busy=%b err=%b code=%b exp all zero",
                     o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code);
        end
        do_reset();
    endtask

    task automatic test_frame();
        send(8'hCA);
        checks++;
        if ({o_busy, o_done, o_address} !== {1'b1, 1'b0, 8'hCA}) begin
            errors++; $display("FAIL frame_addr got busy=%b done=%b addr=%h exp 1 0 ca", o_busy, o_done, o_address);
        end
        send(8'h55);
        checks++;
        if ({o_done, o_dev_sel, o_address, o_request, o_busy} !== {1'b1, 4'b0100, 8'hCA, 8'h55, 1'b1}) begin
            errors++; $display("FAIL frame_done got done=%b sel=%b addr=%h req=%h busy=%b exp 1 0100 ca 55 1",
                               o_done, o_dev_sel, o_address, o_request, o_busy);
        end
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        checks++;
        if ({o_done, o_dev_sel, o_request} !== {1'b1, 4'b0100, 8'h55}) begin
            errors++; $display("FAIL frame_hold got done=%b sel=%b req=%h exp 1 0100 55", o_done, o_dev_sel, o_request);
        end
        tick(0, 8'h00, 1);
        checks++;
        if ({o_done, o_dev_sel, o_busy} !== 6'b0) begin
            errors++; $display("FAIL frame_ack got done=%b sel=%b busy=%b exp 0 0000 0", o_done, o_dev_sel, o_busy);
        end
    endtask

    task automatic test_bad_addr();
        tick(0, 8'h00, 1);
        send(8'h10);
        checks++;
        if ({o_err, o_err_code, o_busy, o_address} !== {1'b1, 2'b01, 1'b0, 8'hCA}) begin
            errors++; $display("FAIL bad_addr got err=%b code=%b busy=%b addr=%h exp 1 01 0 ca", o_err, o_err_code, o_busy, o_address);
        end
        tick(0, 8'h00, 0);
        checks++;
        if ({o_err, o_err_code, o_busy} !== {1'b0, 2'b01, 1'b0}) begin
            errors++; $display("FAIL bad_addr_pulse got err=%b code=%b busy=%b exp 0 01 0", o_err, o_err_code, o_busy);
        end
        send(8'hCB);
        send(8'h01);
        checks++;
        if ({o_dev_sel, o_done, o_request} !== {4'b1000, 1'b1, 8'h01}) begin
            errors++; $display("FAIL bad_addr_next got sel=%b done=%b req=%h exp 1000 1 01", o_dev_sel, o_done, o_request);
        end
        tick(0, 8'h00, 1);
    endtask

    task automatic test_timeout();
        send(8'hC8);
        for (int k = 1; k < TO; k++) tick(0, 8'h00, 0);
        checks++;
        if ({o_err, o_busy} !== 2'b01) begin
            errors++; $display("FAIL timeout_early got err=%b busy=%b exp 0 1", o_err, o_busy);
        end
        tick(0, 8'h00, 0);
        checks++;
        if ({o_err, o_err_code, o_busy, o_done} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
            errors++; $display("FAIL timeout_fire got err=%b code=%b busy=%b done=%b exp 1 10 0 0", o_err, o_err_code, o_busy, o_done);
        end
        tick(0, 8'h00, 0);
        send(8'hC9);
        for (int k = 1; k < TO; k++) tick(0, 8'h00, 0);
        send(8'h44);
        checks++;
        if ({o_err, o_done, o_request, o_dev_sel, o_err_code} !== {1'b0, 1'b1, 8'h44, 4'b0010, 2'b10}) begin
            errors++; $display("FAIL timeout_last_cycle got err=%b done=%b req=%h sel=%b code=%b exp 0 1 44 0010 10",
                               o_err, o_done, o_request, o_dev_sel, o_err_code);
        end
    endtask

    task automatic test_overrun();
        tick(1, 8'hC8, 1);
        checks++;
        if ({o_err, o_err_code, o_done, o_busy, o_address} !== {1'b1, 2'b11, 1'b0, 1'b0, 8'hC9}) begin
            errors++; $display("FAIL ack_and_byte got err=%b code=%b done=%b busy=%b addr=%h exp 1 11 0 0 c9",
                               o_err, o_err_code, o_done, o_busy, o_address);
        end
        tick(0, 8'h00, 0);
        checks++;
        if ({o_busy, o_err} !== 2'b00) begin
            errors++; $display("FAIL ack_and_byte_idle got busy=%b err=%b exp 0 0", o_busy, o_err);
        end
        send(8'h10);
        send(8'hCA);
        send(8'h12);
        send(8'h77);
        checks++;
        if ({o_err, o_err_code, o_request, o_done, o_address} !== {1'b1, 2'b11, 8'h12, 1'b1, 8'hCA}) begin
            errors++; $display("FAIL overrun got err=%b code=%b req=%h done=%b addr=%h exp 1 11 12 1 ca",
                               o_err, o_err_code, o_request, o_done, o_address);
        end
        tick(0, 8'h00, 1);
    endtask

    task automatic test_reset_midframe();
        send(8'hC9);
        #2;
        i_Rst = 1;
        #1;
        checks++;
        if ({o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code} !== 29'd0) begin
            errors++; $display("FAIL reset_midframe got addr=%h req=%h sel=%b done=%b busy=%b err=%b code=%b exp all zero",
                               o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code);
        end
        @(posedge i_Clock);
        #1;
        i_Rst = 0;
        send(8'hC8);
        send(8'h33);
        checks++;
        if ({o_dev_sel, o_request, o_address, o_done} !== {4'b0001, 8'h33, 8'hC8, 1'b1}) begin
            errors++; $display("FAIL reset_restart got sel=%b req=%h addr=%h done=%b exp 0001 33 c8 1",
                               o_dev_sel, o_request, o_address, o_done);
        end
        tick(0, 8'h00, 1);
    endtask

    task automatic test_random();
        bit dd, ack, quiet;
        logic [7:0] d;
        do_reset();
        model_reset();
        for (int i = 0; i < 1200; i++) begin
            quiet = ((i / 150) % 2) == 1;
            dd = quiet ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(196, 207));
            ack = $urandom_range(0, 3) == 0;
            tick(dd, d, ack);
            model_step(dd, d, ack);
            checks++;
            if ({o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code} !==
                {m_addr, m_req, m_sel, m_done, m_busy, m_err, m_code}) begin
                errors++;
                $display("FAIL random cyc %0d got addr=%h req=%h sel=%b done=%b busy=%b err=%b code=%b exp addr=%h req=%h sel=%b done=%b busy=%b err=%b code=%b",
                         i, o_address, o_request, o_dev_sel, o_done, o_busy, o_err, o_err_code,
                         m_addr, m_req, m_sel, m_done, m_busy, m_err, m_code);
            end
            checks++;
            if ($countones(o_dev_sel) > 1) begin
                errors++; $display("FAIL random_onehot cyc %0d got sel=%b exp zero or one-hot", i, o_dev_sel);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame();
        test_bad_addr();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_selector.md
UART_CMD_SELECTOR -- requirements
Module: uart_cmd_selector

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each received byte.
REQ-002 SHALL have parameter NUM_DEV, default 4: number of addressable devices; legal range 1..16.
REQ-003 SHALL have parameter BASE_ADDR, default 8'hC8: first valid device address; BASE_ADDR+NUM_DEV <= 2^DATA_W.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000: maximum number of cycles from address byte to request byte; minimum 2.
REQ-005 SHALL have port i_Clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port i_Data, input, DATA_W: received byte from the UART receiver.
REQ-008 SHALL have port i_Data_Done, input, 1: one-cycle strobe, i_Data valid.
REQ-009 SHALL have port i_Ack, input, 1: consumer acknowledge of a completed frame.
REQ-010 SHALL have port o_address, output, DATA_W: captured address byte.
REQ-011 SHALL have port o_request, output, DATA_W: captured request byte.
REQ-012 SHALL have port o_dev_sel, output, NUM_DEV: one-hot select, bit (o_address-BASE_ADDR), valid while o_done=1.
REQ-013 SHALL have port o_done, output, 1: frame complete, level, held until acknowledged.
REQ-014 SHALL have port o_busy, output, 1: high in WAIT_REQ or HOLD.
REQ-015 SHALL have port o_err, output, 1: one-cycle error pulse.
REQ-016 SHALL have port o_err_code, output, 2: 01 bad address, 10 timeout, 11 overrun; held until next error or reset.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_REQ, HOLD; all outputs registered.
REQ-018 IDLE, i_Data_Done with BASE_ADDR <= i_Data < BASE_ADDR+NUM_DEV: o_address <= i_Data, timeout counter <= 0, go WAIT_REQ.
REQ-019 IDLE, i_Data_Done with i_Data out of range: o_err pulse next cycle, o_err_code <= 01, o_address unchanged, stay IDLE.
REQ-020 WAIT_REQ: counter increments each cycle without i_Data_Done.
REQ-021 WAIT_REQ, i_Data_Done: o_request <= i_Data, o_done <= 1, o_dev_sel set, go HOLD; o_done visible one cycle after strobe.
REQ-022 WAIT_REQ, counter == TIMEOUT_CYC-1 and no i_Data_Done: o_err pulse, o_err_code <= 10, go IDLE; i_Data_Done on that same cycle wins and is accepted as request.
REQ-023 HOLD: o_address, o_request, o_dev_sel, o_done stable until i_Ack.
REQ-024 HOLD, i_Ack: o_done <= 0, o_dev_sel <= 0, go IDLE next cycle.
REQ-025 HOLD, i_Data_Done: byte dropped, o_err pulse, o_err_code <= 11; i_Ack same cycle still honoured (ack wins, byte not reinterpreted as address).
REQ-026 i_Ack outside HOLD SHALL be ignored.
REQ-027 o_dev_sel SHALL be zero or exactly one-hot at all times.

Reset
REQ-028 i_Rst high SHALL immediately force IDLE, counter 0, o_address 0, o_request 0, o_dev_sel 0, o_done 0, o_busy 0, o_err 0, o_err_code 00.
REQ-029 Reset mid-frame SHALL discard the partial frame; first i_Data_Done after release is treated as an address.

Verification (DATA_W=8, NUM_DEV=4, BASE_ADDR=8'hC8, TIMEOUT_CYC=16)
REQ-030 Bytes 0xCA then 0x55 -> o_done=1, o_dev_sel=4'b0100, o_address=0xCA, o_request=0x55; i_Ack -> o_done=0, o_dev_sel=0, o_busy=0 next cycle.
REQ-031 Byte 0x10 in IDLE -> single-cycle o_err, o_err_code=01, o_busy stays 0; then 0xCB, 0x01 -> o_dev_sel=4'b1000.
REQ-032 Byte 0xC8, no further strobe -> o_err with code 10 after 16 cycles, back to IDLE; request strobe on exactly cycle 16 instead -> accepted, o_done=1, no error.
REQ-033 In HOLD, byte 0x77 -> o_err code 11, o_request unchanged; i_Ack and i_Data_Done same cycle -> IDLE, code 11, o_address unchanged.
REQ-034 Byte 0xC9 then i_Rst pulse in WAIT_REQ -> all outputs 0 at once; after release bytes 0xC8, 0x33 -> o_dev_sel=4'b0001, o_request=0x33.
